game_logic_core: RTL and testbench

GAME_LOGIC_CORE -- requirements
Module: game_logic_core

---
 rtl/game_logic_core.sv | 180 ++++++++++++++++++
 tb/tb_game_logic_core.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_logic_core.sv
// game_logic_core: run/dead/clear state machine for the OLED game.
// Latches player/obstacle and player/powerup overlaps pixel by pixel and
// evaluates them once per frame. Advances the score on a fixed tick and
// returns to the menu on a fresh centre-button press.
// Optional feature: define GAME_SHIELD_EN to make powerup channel 0 a
// one-hit shield. Without it, shield_active is tied low.
module game_logic_core #(
  parameter int NUM_POWERUPS = 2,
  parameter int SCORE_WIDTH  = 14,
  parameter int TARGET_SCORE = 9999,
  parameter int TICK_DIV     = 100_000_000
) (
  input  logic                    clock_100mhz,
  input  logic                    reset_n,
  input  logic                    game_active,
  input  logic                    btnC,
  input  logic                    frame_start,
  input  logic                    is_player_hitbox,
  input  logic                    is_obstacle_hitbox,
  input  logic [NUM_POWERUPS-1:0] is_powerup_hitbox,
  output logic [1:0]              state,
  output logic                    is_collision,
  output logic [NUM_POWERUPS-1:0] powerup_collision,
  output logic                    shield_active,
  output logic [SCORE_WIDTH-1:0]  score,
  output logic                    toggle_game_clear_screen,
  output logic                    return_to_menu
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DEAD  = 2'd2,
    S_CLEAR = 2'd3
  } state_e;

  localparam int                     TICK_W     = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0]      TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [SCORE_WIDTH-1:0] SCORE_TGT  = SCORE_WIDTH'(TARGET_SCORE);

  state_e                  state_q, state_d;
  logic [SCORE_WIDTH-1:0]  score_q, score_d;
  logic [TICK_W-1:0]       tick_q, tick_d;
  logic                    obs_latch_q, obs_latch_d;
  logic [NUM_POWERUPS-1:0] pu_latch_q, pu_latch_d;
  logic                    coll_q, coll_d;
  logic [NUM_POWERUPS-1:0] pu_coll_q, pu_coll_d;
  logic                    rtm_q, rtm_d;
  logic                    btn_prev_q;
`ifdef GAME_SHIELD_EN
  logic                    shield_q, shield_d;
  logic                    absorb;
`endif

  logic                    obs_hit;
  logic [NUM_POWERUPS-1:0] pu_hit;
  logic                    btn_rise;
  logic                    fatal;

  assign obs_hit  = is_player_hitbox & is_obstacle_hitbox;
  assign pu_hit   = {NUM_POWERUPS{is_player_hitbox}} & is_powerup_hitbox;
  assign btn_rise = btnC & ~btn_prev_q;

  // Next-state logic: mode transitions, frame evaluation, score tick.
  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    tick_d      = tick_q;
    obs_latch_d = obs_latch_q;
    pu_latch_d  = pu_latch_q;
    coll_d      = 1'b0;
    pu_coll_d   = '0;
    rtm_d       = 1'b0;
    fatal       = 1'b0;
`ifdef GAME_SHIELD_EN
    shield_d    = shield_q;
    absorb      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (game_active) begin
          state_d     = S_RUN;
          score_d     = '0;
          tick_d      = '0;
          obs_latch_d = 1'b0;
          pu_latch_d  = '0;
`ifdef GAME_SHIELD_EN
          shield_d    = 1'b0;
`endif
        end
      end
      S_RUN: begin
        if (!game_active) begin
          state_d = S_IDLE;
        end else begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (score_q != SCORE_TGT) score_d = score_q + SCORE_WIDTH'(1);
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
          if (frame_start) begin
            // Judge the frame just finished; this cycle's overlap opens the next one.
            pu_coll_d   = pu_latch_q;
            obs_latch_d = obs_hit;
            pu_latch_d  = pu_hit;
`ifdef GAME_SHIELD_EN
            // Only a shield held before this frame can absorb its hit.
            absorb   = obs_latch_q & shield_q;
            shield_d = (shield_q & ~obs_latch_q) | pu_latch_q[0];
            fatal    = obs_latch_q & ~absorb;
`else
            fatal    = obs_latch_q;
`endif
          end else begin
            obs_latch_d = obs_latch_q | obs_hit;
            pu_latch_d  = pu_latch_q | pu_hit;
          end
          if (fatal) begin
            coll_d  = 1'b1;
            state_d = S_DEAD;
          end else if (score_q == SCORE_TGT) begin
            state_d = S_CLEAR;
          end
        end
      end
      S_DEAD, S_CLEAR: begin
        if (btn_rise) begin
          rtm_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset discards all partial frame/tick state.
  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      score_q     <= '0;
      tick_q      <= '0;
      obs_latch_q <= 1'b0;
      pu_latch_q  <= '0;
      coll_q      <= 1'b0;
      pu_coll_q   <= '0;
      rtm_q       <= 1'b0;
      btn_prev_q  <= 1'b0;
`ifdef GAME_SHIELD_EN
      shield_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      tick_q      <= tick_d;
      obs_latch_q <= obs_latch_d;
      pu_latch_q  <= pu_latch_d;
      coll_q      <= coll_d;
      pu_coll_q   <= pu_coll_d;
      rtm_q       <= rtm_d;
      btn_prev_q  <= btnC;
`ifdef GAME_SHIELD_EN
      shield_q    <= shield_d;
`endif
    end
  end

  assign state                    = state_q;
  assign is_collision             = coll_q;
  assign powerup_collision        = pu_coll_q;
  assign score                    = score_q;
  assign toggle_game_clear_screen = (state_q == S_CLEAR);
  assign return_to_menu           = rtm_q;
`ifdef GAME_SHIELD_EN
  assign shield_active            = shield_q;
`else
  assign shield_active            = 1'b0;
`endif

endmodule

// File: tb/tb_game_logic_core.sv
// Bench for game_logic_core: directed scenarios followed by random play.
// Each cycle is checked against a reference model, and key points are also
// checked against fixed values.
module tb_game_logic_core;
  localparam int NP  = 2;
  localparam int SW  = 14;
  localparam int TGT = 5;
  localparam int TD  = 4;
`ifdef GAME_SHIELD_EN
  localparam bit SHIELD = 1'b1;
`else
  localparam bit SHIELD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ga = 1'b0, btn = 1'b0, fs = 1'b0, pl = 1'b0, ob = 1'b0;
  logic [NP-1:0] pu = '0;
  logic [1:0]    st;
  logic          coll, shield, clr, rtm;
  logic [NP-1:0] pucoll;
  logic [SW-1:0] score;

  always #5 clk = ~clk;

  game_logic_core #(
    .NUM_POWERUPS(NP), .SCORE_WIDTH(SW), .TARGET_SCORE(TGT), .TICK_DIV(TD)
  ) dut (
    .clock_100mhz(clk), .reset_n(rst_n), .game_active(ga), .btnC(btn),
    .frame_start(fs), .is_player_hitbox(pl), .is_obstacle_hitbox(ob),
    .is_powerup_hitbox(pu), .state(st), .is_collision(coll),
    .powerup_collision(pucoll), .shield_active(shield), .score(score),
    .toggle_game_clear_screen(clr), .return_to_menu(rtm)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: mode code, RUN-cycle count since the game started,
  // per-frame hit flags, shield, button history and expected pulses.
  int          m_state = 0;
  int          m_run   = 0;
  bit          m_obs = 1'b0, m_shield = 1'b0, m_bprev = 1'b0;
  bit [NP-1:0] m_pu = '0;
  bit          e_coll = 1'b0, e_rtm = 1'b0;
  bit [NP-1:0] e_pu = '0;

  function int m_score();
    int s;
    s = m_run / TD;
    return (s > TGT) ? TGT : s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_run = 0; m_obs = 1'b0; m_pu = '0; m_shield = 1'b0;
    m_bprev = 1'b0; e_coll = 1'b0; e_rtm = 1'b0; e_pu = '0;
  endtask

  task automatic model_step();
    int nxt;
    bit at_tgt, hit, deadly;
    nxt = m_state; e_coll = 1'b0; e_rtm = 1'b0; e_pu = '0;
    case (m_state)
      0: if (ga) begin
        nxt = 1; m_run = 0; m_obs = 1'b0; m_pu = '0; m_shield = 1'b0;
      end
      1: if (!ga) nxt = 0;
         else begin
           at_tgt = (m_score() == TGT);
           m_run++;
           deadly = 1'b0;
           if (fs) begin
             hit  = m_obs;
             e_pu = m_pu;
             deadly = hit && !(SHIELD && m_shield);
             if (SHIELD) m_shield = (m_shield && !hit) || m_pu[0];
             m_obs = pl && ob;
             m_pu  = pu & {NP{pl}};
           end else begin
             m_obs = m_obs || (pl && ob);
             m_pu  = m_pu | (pu & {NP{pl}});
           end
           if (deadly) begin nxt = 2; e_coll = 1'b1; end
           else if (at_tgt) nxt = 3;
         end
      default: if (btn && !m_bprev) begin e_rtm = 1'b1; nxt = 0; end
    endcase
    m_bprev = btn;
    m_state = nxt;
  endtask

  task automatic check_all();
    chk("state", 32'(st), 32'(m_state));
    chk("score", 32'(score), 32'(m_score()));
    chk("is_collision", 32'(coll), 32'(e_coll));
    chk("powerup_collision", 32'(pucoll), 32'(e_pu));
    chk("shield_active", 32'(shield), 32'(m_shield));
    chk("clear_screen", 32'(clr), 32'(m_state == 3));
    chk("return_to_menu", 32'(rtm), 32'(e_rtm));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 32'(st), 0);
    chk({tag, "_score"}, 32'(score), 0);
    chk({tag, "_coll"}, 32'(coll), 0);
    chk({tag, "_pucoll"}, 32'(pucoll), 0);
    chk({tag, "_shield"}, 32'(shield), 0);
    chk({tag, "_clr"}, 32'(clr), 0);
    chk({tag, "_rtm"}, 32'(rtm), 0);
  endtask

  initial begin
    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("por");
    rst_n = 1'b1;
    model_reset();
    step();

    // Run to the target score, then leave via button
    ga = 1'b1; step();
    repeat (20) step();
    chk("tgt_score", 32'(score), 5);
    chk("tgt_state_run", 32'(st), 1);
    step();
    chk("clear_state", 32'(st), 3);
    chk("clear_toggle", 32'(clr), 1);
    ga = 1'b0; btn = 1'b1; step();
    chk("clear_rtm", 32'(rtm), 1);
    chk("clear_exit_state", 32'(st), 0);
    btn = 1'b0; step();
    chk("clear_rtm_off", 32'(rtm), 0);

    // Fatal collision, button held across entry into DEAD
    ga = 1'b1; step();
    step(); step();
    pl = 1'b1; ob = 1'b1; step();
    pl = 1'b0; ob = 1'b0; btn = 1'b1; step(); step();
    fs = 1'b1; step();
    chk("hit_coll", 32'(coll), 1);
    chk("hit_state", 32'(st), 2);
    fs = 1'b0; step();
    chk("hit_coll_off", 32'(coll), 0);
    repeat (5) step();
    chk("dead_score_frozen", 32'(score), 1);
    chk("dead_btn_held", 32'(st), 2);
    btn = 1'b0; step();
    ga = 1'b0; btn = 1'b1; step();
    chk("dead_rtm", 32'(rtm), 1);
    chk("dead_exit", 32'(st), 0);
    btn = 1'b0; step();

    // Powerup pulse, then overlap on the frame_start cycle itself
    ga = 1'b1; step();
    pl = 1'b1; pu = 2'b10; step();
    pl = 1'b0; pu = 2'b00; step();
    fs = 1'b1; step();
    chk("pu_pulse", 32'(pucoll), 2);
    chk("pu_state", 32'(st), 1);
    fs = 1'b0; step();
    chk("pu_pulse_off", 32'(pucoll), 0);
    fs = 1'b1; pl = 1'b1; ob = 1'b1; step();
    chk("fs_overlap_not_yet", 32'(coll), 0);
    fs = 1'b0; pl = 1'b0; ob = 1'b0; step(); step();
    fs = 1'b1; step();
    chk("fs_overlap_next", 32'(coll), 1);
    fs = 1'b0; ga = 1'b0; step();
    btn = 1'b1; step();
    btn = 1'b0; step();

    // Shield absorbs one hit
    ga = 1'b1; step();
    pl = 1'b1; pu = 2'b01; step();
    pl = 1'b0; pu = 2'b00; fs = 1'b1; step();
    chk("sh_pu_pulse", 32'(pucoll), 1);
    chk("sh_set", 32'(shield), 32'(SHIELD));
    fs = 1'b0; pl = 1'b1; ob = 1'b1; step();
    pl = 1'b0; ob = 1'b0; fs = 1'b1; step();
    fs = 1'b0;
`ifdef GAME_SHIELD_EN
    chk("sh_absorb_coll", 32'(coll), 0);
    chk("sh_absorb_state", 32'(st), 1);
    chk("sh_cleared", 32'(shield), 0);
    pl = 1'b1; ob = 1'b1; step();
    pl = 1'b0; ob = 1'b0; fs = 1'b1; step();
    fs = 1'b0;
    chk("sh_second_hit", 32'(st), 2);
    chk("sh_second_coll", 32'(coll), 1);
    ga = 1'b0; btn = 1'b1; step();
    btn = 1'b0; step();
    // Shield from the same frame as the hit does not protect
    ga = 1'b1; step();
    pl = 1'b1; ob = 1'b1; pu = 2'b01; step();
    pl = 1'b0; ob = 1'b0; pu = 2'b00; fs = 1'b1; step();
    fs = 1'b0;
    chk("sh_same_frame", 32'(st), 2);
`else
    chk("nosh_hit_state", 32'(st), 2);
    chk("nosh_shield", 32'(shield), 0);
`endif
    ga = 1'b0; btn = 1'b1; step();
    btn = 1'b0; step();

    // Collision evaluated on the cycle score sits at the target
    ga = 1'b1; step();
    for (int i = 0; i < 20; i++) begin
      pl = (i == 10); ob = (i == 10);
      step();
    end
    pl = 1'b0; ob = 1'b0;
    chk("race_score", 32'(score), 5);
    fs = 1'b1; step();
    fs = 1'b0;
    chk("race_dead", 32'(st), 2);
    chk("race_coll", 32'(coll), 1);
    ga = 1'b0; btn = 1'b1; step();
    btn = 1'b0; step();

    // Asynchronous reset in the middle of a run
    ga = 1'b1; step();
    repeat (3) step();
    pl = 1'b1; ob = 1'b1; pu = 2'b11; step();
    repeat (3) step();
    chk("pre_rst_score", 32'(score), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    ga = 1'b0; pl = 1'b0; ob = 1'b0; pu = '0;
    @(posedge clk);
    #1;
    chk_all_zero("held_rst");
    rst_n = 1'b1;
    model_reset();
    step();

    // Random play against the model
    for (int i = 0; i < 1500; i++) begin
      ga = ($urandom_range(0, 99) < 97);
      if ($urandom_range(0, 9) == 0) btn = ~btn;
      fs = ($urandom_range(0, 7) == 0);
      pl = ($urandom_range(0, 1) == 1);
      ob = ($urandom_range(0, 9) == 0);
      pu = {($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0)};
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
